// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants and types for the sequential ALU unit.
//                ALU control codes, R-type funct encodings, ALUOp encodings,
//                FSM state type and the ALUOp/funct decode function.
//                Configuration macro ALU_MULT_EN: when defined, funct 011000
//                decodes to MUL; otherwise it falls to the illegal/ADD rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control codes presented on alu_ctrl
    localparam logic [3:0] c_CTRL_AND = 4'b0000;
    localparam logic [3:0] c_CTRL_OR  = 4'b0001;
    localparam logic [3:0] c_CTRL_ADD = 4'b0010;
    localparam logic [3:0] c_CTRL_SUB = 4'b0110;
    localparam logic [3:0] c_CTRL_SLT = 4'b0111;
    localparam logic [3:0] c_CTRL_NOR = 4'b1100;
    localparam logic [3:0] c_CTRL_MUL = 4'b1000;

    // R-type funct field encodings
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;
    localparam logic [5:0] c_FN_NOR = 6'b100111;
    localparam logic [5:0] c_FN_MUL = 6'b011000;

    // ALUOp encodings from the main control unit
    localparam logic [1:0] c_OP_ADD   = 2'b00;
    localparam logic [1:0] c_OP_SUB   = 2'b01;
    localparam logic [1:0] c_OP_RTYPE = 2'b10;

    // FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t c_ST_IDLE = 1'b0;
    localparam state_t c_ST_MULT = 1'b1;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       illegal;
    } decode_t;

    // Anything not explicitly listed decodes as ADD and is flagged illegal.
    function automatic decode_t alu_decode(input logic [1:0] op, input logic [5:0] fn);
        decode_t d;
        d.ctrl    = c_CTRL_ADD;
        d.illegal = 1'b0;
        case (op)
            c_OP_ADD: d.ctrl = c_CTRL_ADD;
            c_OP_SUB: d.ctrl = c_CTRL_SUB;
            c_OP_RTYPE: begin
                case (fn)
                    c_FN_ADD: d.ctrl = c_CTRL_ADD;
                    c_FN_SUB: d.ctrl = c_CTRL_SUB;
                    c_FN_AND: d.ctrl = c_CTRL_AND;
                    c_FN_OR:  d.ctrl = c_CTRL_OR;
                    c_FN_SLT: d.ctrl = c_CTRL_SLT;
                    c_FN_NOR: d.ctrl = c_CTRL_NOR;
`ifdef ALU_MULT_EN
                    c_FN_MUL: d.ctrl = c_CTRL_MUL;
`endif
                    default:  d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mult_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mult_iter
//  Description : Iterative unsigned shift-add multiplier, one partial product
//                per cycle, WIDTH iterations per operation. Keeps the low
//                WIDTH bits of the product.
//                Compiled only when ALU_MULT_EN is defined.
//  Ports       : clk, rst_n (async, active low), start (load operands a/b),
//                abort (cancel in-flight op), busy (iterations remaining),
//                done (final iteration happens at the coming edge),
//                product (valid while done is high)
//  Revision    : 1.0 - initial release
// ============================================================================
`ifdef ALU_MULT_EN
module alu_mult_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int c_CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] w_acc_nxt;

    // Accumulator after the current iteration; on the last iteration this is
    // the finished product, so it is handed out combinationally with done.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign busy      = (r_count != '0);
    assign done      = (r_count == c_CW'(1));
    assign product   = w_acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (abort) begin
            r_count  <= '0;
        end else if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= c_CW'(WIDTH);
        end else if (busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - c_CW'(1);
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_unit
//  Description : ALU control decode + execute with registered result.
//                Single-cycle ops accept one per cycle with latency 1.
//                With ALU_MULT_EN defined, MUL runs on an iterative
//                multiplier for WIDTH cycles while in_ready is held low.
//  Ports       : clk, rst_n (async, active low)
//                alu_op[1:0], funct[5:0], a, b, in_valid / in_ready
//                flush (abort in-flight op, drop pending output)
//                result, zero, alu_ctrl[3:0], illegal, out_valid (1-cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       alu_ctrl,
    output logic             illegal,
    output logic             out_valid
);

    decode_t          w_dec;
    logic [WIDTH-1:0] w_exec;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_product;

    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_ctrl;
    logic             r_illegal;
    logic             r_out_valid;

    assign w_dec    = alu_decode(alu_op, funct);
    assign w_accept = in_valid & in_ready;

    // Single-cycle execute; MUL never reaches this path.
    always_comb begin
        w_exec = a + b;
        case (w_dec.ctrl)
            c_CTRL_AND: w_exec = a & b;
            c_CTRL_OR:  w_exec = a | b;
            c_CTRL_SUB: w_exec = a - b;
            c_CTRL_SLT: w_exec = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_CTRL_NOR: w_exec = ~(a | b);
            default:    w_exec = a + b;
        endcase
    end

`ifdef ALU_MULT_EN
    state_t r_state;
    state_t w_state_nxt;
    logic   w_mul_busy;

    assign w_is_mul = (w_dec.ctrl == c_CTRL_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (w_accept && w_is_mul) w_state_nxt = c_ST_MULT;
                c_ST_MULT: if (w_mul_done)           w_state_nxt = c_ST_IDLE;
                default:                             w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Busy is redundant with the MULT state; it guards against any skew
    // between the FSM and the multiplier's own iteration counter.
    always_comb begin
        in_ready = (r_state == c_ST_IDLE) & ~w_mul_busy & ~flush;
    end

    alu_mult_iter #(
        .WIDTH   (WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept & w_is_mul),
        .a       (a),
        .b       (b),
        .abort   (flush),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );
`else
    assign w_is_mul      = 1'b0;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;

    always_comb begin
        in_ready = ~flush;
    end
`endif

    // Result registers only change on a completion; flush drops the pulse
    // and leaves the previous result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_ctrl      <= c_CTRL_ADD;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (!flush) begin
                if (w_mul_done) begin
                    r_result    <= w_mul_product;
                    r_ctrl      <= c_CTRL_MUL;
                    r_illegal   <= 1'b0;
                    r_out_valid <= 1'b1;
                end else if (w_accept && !w_is_mul) begin
                    r_result    <= w_exec;
                    r_ctrl      <= w_dec.ctrl;
                    r_illegal   <= w_dec.illegal;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    assign result    = r_result;
    assign zero      = (r_result == '0);
    assign alu_ctrl  = r_ctrl;
    assign illegal   = r_illegal;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq_unit
//  Description : Self-checking bench for alu_seq_unit (WIDTH=8). A transaction
//                level model predicts every output each cycle; directed
//                sequences pin known values, then randomized traffic runs.
//                Honours ALU_MULT_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    localparam int WIDTH = 8;
`ifdef ALU_MULT_EN
    localparam bit MULT_ON = 1'b1;
`else
    localparam bit MULT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a, b;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [3:0]       alu_ctrl;
    logic             illegal;
    logic             out_valid;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    alu_seq_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_op    (alu_op),
        .funct     (funct),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .result    (result),
        .zero      (zero),
        .alu_ctrl  (alu_ctrl),
        .illegal   (illegal),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Operation semantics from the instruction's point of view.
    task automatic ref_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] r, output logic [3:0] c,
                          output logic il, output logic mul);
        int sx, sy;
        logic [15:0] p;
        sx  = x[7] ? int'(x) - 256 : int'(x);
        sy  = y[7] ? int'(y) - 256 : int'(y);
        p   = 16'(x) * 16'(y);
        mul = 1'b0;
        il  = 1'b0;
        r   = 8'((int'(x) + int'(y)) % 256);
        c   = 4'b0010;
        if (op == 2'b01) begin
            r = 8'((int'(x) - int'(y) + 256) % 256);
            c = 4'b0110;
        end else if (op == 2'b11) begin
            il = 1'b1;
        end else if (op == 2'b10) begin
            case (fn)
                6'b100000: ;
                6'b100010: begin r = 8'((int'(x) - int'(y) + 256) % 256); c = 4'b0110; end
                6'b100100: begin r = x & y;                 c = 4'b0000; end
                6'b100101: begin r = x | y;                 c = 4'b0001; end
                6'b101010: begin r = (sx < sy) ? 8'd1 : 8'd0; c = 4'b0111; end
                6'b100111: begin r = ~(x | y);              c = 4'b1100; end
                6'b011000: begin
                    if (MULT_ON) begin mul = 1'b1; r = p[7:0]; c = 4'b1000; end
                    else il = 1'b1;
                end
                default:   il = 1'b1;
            endcase
        end
    endtask

    int         m_busy;     // cycles left before a MUL completes
    logic [7:0] m_res, m_prod;
    logic [3:0] m_ctrl;
    logic       m_ill, m_ov;

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] r;
        logic [3:0] c;
        logic       il, mul;
        if (!rst_n) begin
            m_busy = 0; m_res = 8'h00; m_prod = 8'h00;
            m_ctrl = 4'b0010; m_ill = 1'b0; m_ov = 1'b0;
        end else begin
            m_ov = 1'b0;
            if (flush) begin
                m_busy = 0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_res = m_prod; m_ctrl = 4'b1000; m_ill = 1'b0; m_ov = 1'b1;
                end
            end else if (in_valid) begin
                ref_op(alu_op, funct, a, b, r, c, il, mul);
                if (mul) begin
                    m_busy = WIDTH; m_prod = r;
                end else begin
                    m_res = r; m_ctrl = c; m_ill = il; m_ov = 1'b1;
                end
            end
        end
    end

    // One full-output comparison per cycle.
    always @(negedge clk) begin
        logic exp_rdy;
        if (cmp_en) begin
            exp_rdy = (m_busy == 0) && !flush;
            checks++;
            if ({out_valid, in_ready, result, zero, alu_ctrl, illegal} !==
                {m_ov, exp_rdy, m_res, (m_res == 8'h00), m_ctrl, m_ill}) begin
                failures++;
                $display("FAIL model_cmp t=%0t got ov=%b rdy=%b res=%h z=%b ctrl=%b ill=%b expected ov=%b rdy=%b res=%h z=%b ctrl=%b ill=%b",
                         $time, out_valid, in_ready, result, zero, alu_ctrl, illegal,
                         m_ov, exp_rdy, m_res, (m_res == 8'h00), m_ctrl, m_ill);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [7:0] x, input logic [7:0] y);
        in_valid = v; alu_op = op; funct = fn; a = x; b = y;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single op: accept at next edge, then sample the cycle after it.
    task automatic op1(input logic [1:0] op, input logic [5:0] fn,
                       input logic [7:0] x, input logic [7:0] y);
        step();
        drive(1'b1, op, fn, x, y);
        step();
        drive(1'b0, 2'b00, 6'd0, 8'd0, 8'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [5:0] fl [8];

    initial begin
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
               6'b101010, 6'b100111, 6'b011000, 6'b111111};
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'b00, 6'd0, 8'd0, 8'd0);

        // Reset values while rst_n is low, mid-cycle.
        #22;
        chk("rst_result", result, 8'h00);
        chk("rst_zero", zero, 1'b1);
        chk("rst_ctrl", alu_ctrl, 4'b0010);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        cmp_en = 1'b1;

        // Back-to-back R-type: ADD, SUB, SLT.
        step();
        drive(1'b1, 2'b10, 6'b100000, 8'd5, 8'd3);
        step();
        drive(1'b1, 2'b10, 6'b100010, 8'd3, 8'd5);
        @(negedge clk);
        chk("b2b_add_ov", out_valid, 1'b1);
        chk("b2b_add_res", result, 8'h08);
        step();
        drive(1'b1, 2'b10, 6'b101010, 8'hF0, 8'h01);
        @(negedge clk);
        chk("b2b_sub_ov", out_valid, 1'b1);
        chk("b2b_sub_res", result, 8'hFE);
        chk("b2b_sub_ctrl", alu_ctrl, 4'b0110);
        step();
        drive(1'b0, 2'b00, 6'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("b2b_slt_ov", out_valid, 1'b1);
        chk("b2b_slt_res", result, 8'h01);
        chk("b2b_slt_zero", zero, 1'b0);
        chk("b2b_slt_ctrl", alu_ctrl, 4'b0111);

        // SUB to zero, then unknown funct.
        op1(2'b01, 6'd0, 8'h2A, 8'h2A);
        chk("sub0_res", result, 8'h00);
        chk("sub0_zero", zero, 1'b1);
        chk("sub0_ctrl", alu_ctrl, 4'b0110);
        op1(2'b10, 6'b111111, 8'd7, 8'd9);
        chk("illfn_res", result, 8'h10);
        chk("illfn_ill", illegal, 1'b1);
        chk("illfn_ctrl", alu_ctrl, 4'b0010);
        op1(2'b11, 6'b100010, 8'd1, 8'd1);
        chk("op11_res", result, 8'h02);
        chk("op11_ill", illegal, 1'b1);

`ifdef ALU_MULT_EN
        // MUL 13x11: out_valid exactly WIDTH cycles after accept.
        step();
        drive(1'b1, 2'b10, 6'b011000, 8'd13, 8'd11);
        step();
        drive(1'b0, 2'b00, 6'd0, 8'd0, 8'd0);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            chk("mul1_busy_ov", out_valid, 1'b0);
            chk("mul1_busy_rdy", in_ready, 1'b0);
        end
        @(negedge clk);
        chk("mul1_ov", out_valid, 1'b1);
        chk("mul1_res", result, 8'h8F);
        chk("mul1_ctrl", alu_ctrl, 4'b1000);
        chk("mul1_rdy", in_ready, 1'b1);

        // MUL 200x3, in_valid kept high with a pending ADD behind it.
        step();
        drive(1'b1, 2'b10, 6'b011000, 8'd200, 8'd3);
        step();
        drive(1'b1, 2'b10, 6'b100000, 8'd1, 8'd1);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            chk("mul2_busy_rdy", in_ready, 1'b0);
        end
        drive(1'b0, 2'b00, 6'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("mul2_ov", out_valid, 1'b1);
        chk("mul2_res", result, 8'h58);

        // Flush three cycles into a MUL with in_valid held high.
        step();
        drive(1'b1, 2'b10, 6'b011000, 8'd9, 8'd9);
        step();
        drive(1'b1, 2'b10, 6'b100000, 8'd1, 8'd1);
        step();
        step();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_rdy_low", in_ready, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 2'b00, 6'd0, 8'd0, 8'd0);
        @(negedge clk);
        chk("flush_ov", out_valid, 1'b0);
        chk("flush_rdy", in_ready, 1'b1);
        chk("flush_res_held", result, 8'h58);
        chk("flush_ctrl_held", alu_ctrl, 4'b1000);
        for (int k = 0; k < 2 * WIDTH; k++) begin
            @(negedge clk);
            chk("flush_no_ov", out_valid, 1'b0);
        end
`else
        // Without the multiplier, MUL funct is an illegal ADD with latency 1.
        op1(2'b10, 6'b011000, 8'd2, 8'd3);
        chk("nomul_ov", out_valid, 1'b1);
        chk("nomul_res", result, 8'h05);
        chk("nomul_ill", illegal, 1'b1);
        chk("nomul_ctrl", alu_ctrl, 4'b0010);
`endif

        // Reset asserted mid-cycle shortly after a MUL-funct accept.
        step();
        drive(1'b1, 2'b10, 6'b011000, 8'd4, 8'd5);
        step();
        drive(1'b0, 2'b00, 6'd0, 8'd0, 8'd0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 8'h00);
        chk("midrst_zero", zero, 1'b1);
        chk("midrst_ctrl", alu_ctrl, 4'b0010);
        chk("midrst_illegal", illegal, 1'b0);
        chk("midrst_ov", out_valid, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            chk("midrst_no_ov", out_valid, 1'b0);
        end

        // Randomized traffic; the model checks every cycle.
        for (int n = 0; n < 800; n++) begin
            int sel;
            step();
            sel      = int'($urandom_range(0, 9));
            in_valid = ($urandom_range(0, 3) != 0);
            alu_op   = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : (sel == 2) ? 2'b11 : 2'b10;
            funct    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fl[$urandom_range(0, 7)];
            a        = 8'($urandom);
            b        = ($urandom_range(0, 5) == 0) ? a : 8'($urandom);
            flush    = ($urandom_range(0, 15) == 0);
        end
        step();
        drive(1'b0, 2'b00, 6'd0, 8'd0, 8'd0);
        flush = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
